// File: rtl/sram_1rw1r_ctrl.sv
// Valid/ready front-end for a 512x32 1RW+1R SRAM macro: drives the macro pins
// straight from accepted requests and returns read data through per-port FIFOs.

module sram_1rw1r_rsp_q #(
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_fire_i,
  input  logic                  rsp_ready_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  req_ready_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o
);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);
  localparam logic [OW-1:0] DEPTH_O  = OW'(RSP_DEPTH);

  logic                  infl_q;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic                  push_s, pop_s;
  logic [OW-1:0]         occ_s;

  assign rsp_valid_o = (count_q != {CW{1'b0}});
  assign rsp_rdata_o = mem_q[rptr_q];
  assign push_s      = infl_q;
  assign pop_s       = rsp_valid_o && rsp_ready_i;

  // Occupancy after this cycle counts the read already in the macro, so an
  // accepted read always finds a free slot even with rsp_ready held low.
  assign occ_s       = {1'b0, count_q} + OW'(infl_q) - OW'(pop_s);
  assign req_ready_o = rst_n && (occ_s < DEPTH_O);

  always_comb begin
    count_d = count_q + CW'(push_s) - CW'(pop_s);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push_s) begin
      wptr_d = (wptr_q == LAST_PTR) ? {PW{1'b0}} : wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = (rptr_q == LAST_PTR) ? {PW{1'b0}} : rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q  <= 1'b0;
      count_q <= {CW{1'b0}};
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      infl_q  <= rd_fire_i;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      if (push_s) begin
        mem_q[wptr_q] <= dout_i;
      end
    end
  end
endmodule

module sram_1rw1r_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [NUM_WMASKS-1:0] p0_req_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  logic p0_fire_s, p0_rd_fire_s, p1_fire_s, p1_q_ready_s, collide_s;

  assign p0_fire_s    = p0_req_valid && p0_req_ready;
  assign p0_rd_fire_s = p0_fire_s && !p0_req_we;

  // Port 1 yields to a same-address port-0 write; the macro output is undefined then.
  assign collide_s    = p0_fire_s && p0_req_we && (p0_req_addr == p1_req_addr);
  assign p1_req_ready = p1_q_ready_s && !collide_s;
  assign p1_fire_s    = p1_req_valid && p1_req_ready;

  assign sram_csb0   = !p0_fire_s;
  assign sram_web0   = !p0_req_we;
  assign sram_wmask0 = p0_req_wmask;
  assign sram_addr0  = p0_req_addr;
  assign sram_din0   = p0_req_wdata;
  assign sram_csb1   = !p1_fire_s;
  assign sram_addr1  = p1_req_addr;

  sram_1rw1r_rsp_q #(.DATA_WIDTH(DATA_WIDTH), .RSP_DEPTH(RSP_DEPTH)) u_p0_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_fire_i   (p0_rd_fire_s),
    .rsp_ready_i (p0_rsp_ready),
    .dout_i      (sram_dout0),
    .req_ready_o (p0_req_ready),
    .rsp_valid_o (p0_rsp_valid),
    .rsp_rdata_o (p0_rsp_rdata)
  );

  sram_1rw1r_rsp_q #(.DATA_WIDTH(DATA_WIDTH), .RSP_DEPTH(RSP_DEPTH)) u_p1_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_fire_i   (p1_fire_s),
    .rsp_ready_i (p1_rsp_ready),
    .dout_i      (sram_dout1),
    .req_ready_o (p1_q_ready_s),
    .rsp_valid_o (p1_rsp_valid),
    .rsp_rdata_o (p1_rsp_rdata)
  );
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Directed bench for sram_1rw1r_ctrl with a behavioural 1RW+1R macro model
// (pins sampled on posedge, write and read-out on the following negedge).

module tb_sram_1rw1r_ctrl;
  logic        clk;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [3:0]  p0_req_wmask;
  logic [8:0]  p0_req_addr;
  logic [31:0] p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_ready;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready;
  logic [8:0]  p1_req_addr;
  logic        p1_rsp_valid, p1_rsp_ready;
  logic [31:0] p1_rsp_rdata;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;

  int n_cmp = 0;
  int n_err = 0;

  sram_1rw1r_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_wmask(p0_req_wmask), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model
  logic [31:0] mem [0:511];
  logic        lat_csb0, lat_web0, lat_csb1;
  logic [3:0]  lat_mask0;
  logic [8:0]  lat_addr0, lat_addr1;
  logic [31:0] lat_din0;

  always @(posedge clk) begin
    lat_csb0  <= sram_csb0;
    lat_web0  <= sram_web0;
    lat_mask0 <= sram_wmask0;
    lat_addr0 <= sram_addr0;
    lat_din0  <= sram_din0;
    lat_csb1  <= sram_csb1;
    lat_addr1 <= sram_addr1;
  end

  always @(negedge clk) begin
    if (lat_csb0 === 1'b0 && lat_web0 === 1'b0) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_mask0[b]) mem[lat_addr0][b*8 +: 8] <= lat_din0[b*8 +: 8];
      end
    end
    if (lat_csb0 === 1'b0 && lat_web0 === 1'b1) sram_dout0 <= mem[lat_addr0];
    if (lat_csb1 === 1'b0) sram_dout1 <= mem[lat_addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [8:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input string name);
    p0_req_valid = 1'b1; p0_req_we = 1'b1;
    p0_req_addr = addr; p0_req_wdata = data; p0_req_wmask = mask;
    @(negedge clk);
    chk({name, "/ready"}, 32'(p0_req_ready), 32'd1);
    chk({name, "/csb0"}, 32'(sram_csb0), 32'd0);
    chk({name, "/web0"}, 32'(sram_web0), 32'd0);
    tick();
    p0_req_valid = 1'b0; p0_req_we = 1'b0;
  endtask

  // Read with exact latency check: nothing in N+1, data in N+2.
  task automatic do_read(input bit port, input logic [8:0] addr,
                         input logic [31:0] exp, input string name);
    if (!port) begin
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = addr;
    end else begin
      p1_req_valid = 1'b1; p1_req_addr = addr;
    end
    @(negedge clk);
    chk({name, "/ready"}, 32'(port ? p1_req_ready : p0_req_ready), 32'd1);
    tick();
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    @(negedge clk);
    chk({name, "/early"}, 32'(port ? p1_rsp_valid : p0_rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk({name, "/valid"}, 32'(port ? p1_rsp_valid : p0_rsp_valid), 32'd1);
    chk({name, "/rdata"}, port ? p1_rsp_rdata : p0_rsp_rdata, exp);
    tick();
  endtask

  typedef struct {
    bit          we;
    bit          port;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];
  int   exp_rdy[7];
  int   exp_rv[10];
  int   exp_rd[10];
  int   k;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 9'h005, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 9'h005, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 9'h1FF, 32'h11223344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 9'h1FF, 32'hAABBCCDD, 4'h5, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 9'h1FF, 32'h0,        4'h0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 1'b0, 9'h020, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 9'h020, 32'h00000000, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 9'h020, 32'h0,        4'h0, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 1'b0, 9'h021, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 9'h021, 32'h01234567, 4'hA, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 9'h021, 32'h0,        4'h0, 32'h01FF45FF};
    exp_rdy = '{1, 1, 0, 0, 0, 1, 1};
    exp_rv  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    exp_rd  = '{0, 0, 0, 0, 0, 0, 3, 6, 9, 0};

    // Reset with requests pending
    rst_n = 1'b0;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_wmask = 4'h0;
    p0_req_addr = 9'h005; p0_req_wdata = 32'h0; p0_rsp_ready = 1'b1;
    p1_req_valid = 1'b1; p1_req_addr = 9'h006; p1_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst/p0_ready", 32'(p0_req_ready), 32'd0);
    chk("rst/p1_ready", 32'(p1_req_ready), 32'd0);
    chk("rst/csb0", 32'(sram_csb0), 32'd1);
    chk("rst/csb1", 32'(sram_csb1), 32'd1);
    chk("rst/p0_valid", 32'(p0_rsp_valid), 32'd0);
    chk("rst/p1_valid", 32'(p1_rsp_valid), 32'd0);
    chk("rst/p0_rdata", p0_rsp_rdata, 32'd0);
    chk("rst/p1_rdata", p1_rsp_rdata, 32'd0);
    tick();
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, $sformatf("vec%0d", i));
      else do_read(vecs[i].port, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Streaming on port 1
    for (int i = 0; i < 8; i++) do_write(9'(i), 32'(i * 3), 4'hF, "preload");
    for (int i = 0; i < 10; i++) begin
      p1_req_valid = (i < 8); p1_req_addr = 9'(i);
      @(negedge clk);
      if (i < 8) chk("stream/ready", 32'(p1_req_ready), 32'd1);
      chk("stream/valid", 32'(p1_rsp_valid), (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) chk("stream/rdata", p1_rsp_rdata, 32'((i - 2) * 3));
      tick();
    end
    p1_req_valid = 1'b0;
    @(negedge clk);
    chk("stream/drained", 32'(p1_rsp_valid), 32'd0);
    tick();

    // Backpressure on port 0
    k = 0;
    for (int c = 0; c < 10; c++) begin
      p0_rsp_ready = (c >= 5); p0_req_valid = (k < 4); p0_req_we = 1'b0; p0_req_addr = 9'(k);
      @(negedge clk);
      if (c < 7) chk($sformatf("bp/ready c%0d", c), 32'(p0_req_ready), 32'(exp_rdy[c]));
      chk($sformatf("bp/valid c%0d", c), 32'(p0_rsp_valid), 32'(exp_rv[c]));
      if (exp_rv[c] != 0) chk($sformatf("bp/rdata c%0d", c), p0_rsp_rdata, 32'(exp_rd[c]));
      if (p0_req_valid && p0_req_ready) k++;
      tick();
    end
    p0_req_valid = 1'b0; p0_rsp_ready = 1'b1;
    chk("bp/accepted", 32'(k), 32'd4);

    // Different addresses: no stall on port 1
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 9'h011;
    p0_req_wdata = 32'h00000001; p0_req_wmask = 4'hF;
    p1_req_valid = 1'b1; p1_req_addr = 9'h005;
    @(negedge clk);
    chk("nocoll/p1_ready", 32'(p1_req_ready), 32'd1);
    tick();
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p1_req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("nocoll/valid", 32'(p1_rsp_valid), 32'd1);
    chk("nocoll/rdata", p1_rsp_rdata, 32'd15);
    tick();

    // Same-address collision
    p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 9'h010;
    p0_req_wdata = 32'h5A5A1234; p0_req_wmask = 4'hF;
    p1_req_valid = 1'b1; p1_req_addr = 9'h010;
    @(negedge clk);
    chk("coll/p0_ready", 32'(p0_req_ready), 32'd1);
    chk("coll/p1_ready", 32'(p1_req_ready), 32'd0);
    chk("coll/csb1", 32'(sram_csb1), 32'd1);
    tick();
    p0_req_valid = 1'b0; p0_req_we = 1'b0;
    @(negedge clk);
    chk("coll/p1_ready_next", 32'(p1_req_ready), 32'd1);
    chk("coll/csb1_next", 32'(sram_csb1), 32'd0);
    tick();
    p1_req_valid = 1'b0;
    @(negedge clk);
    chk("coll/early", 32'(p1_rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("coll/valid", 32'(p1_rsp_valid), 32'd1);
    chk("coll/rdata", p1_rsp_rdata, 32'h5A5A1234);
    tick();

    // Reset one cycle after a read fire
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 9'h005;
    tick();
    p0_req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midrst/valid", 32'(p0_rsp_valid), 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
